// File: rtl/avg_128_demod_pkg.sv
// Shared definitions for the FM discriminator / moving-average block.
// Optional build macro: AVG_128_DEMOD_ROUND_EN (round-half-up shifts).
package avg_128_demod_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_AVG_LOG2 = 7;

    // Full-precision width of prev_r*cur_i - prev_i*cur_r.
    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Running-sum width: 2^avg_log2 values of w bits can never overflow it.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned avg_log2);
        return w + avg_log2;
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x,
                                                        input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/avg_128_demod_conj_disc.sv
// Stages 0-1: sample capture and Im{x[n]*conj(x[n-1])} discriminator,
// scaled by 2^-(WIDTH-1) and saturated to WIDTH bits.
// Optional build macro: AVG_128_DEMOD_ROUND_EN (round half-up before scaling).
module avg_128_demod_conj_disc
    import avg_128_demod_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic signed [WIDTH-1:0] real_i,
    input  logic signed [WIDTH-1:0] imag_i,
    output logic signed [WIDTH-1:0] d,
    output logic                    d_valid
);

    localparam int unsigned PROD_W = prod_width(WIDTH);
    localparam int unsigned SHIFT  = WIDTH - 1;
`ifdef AVG_128_DEMOD_ROUND_EN
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) << (SHIFT - 1);
`endif

    logic signed [WIDTH-1:0]  cur_re;
    logic signed [WIDTH-1:0]  cur_im;
    logic signed [WIDTH-1:0]  prev_re;
    logic signed [WIDTH-1:0]  prev_im;
    logic                     v1;
    logic signed [PROD_W-1:0] prod_a;
    logic signed [PROD_W-1:0] prod_b;
    logic signed [PROD_W-1:0] disc;
    logic signed [PROD_W-1:0] disc_adj;
    logic signed [PROD_W-1:0] disc_shift;
    logic signed [WIDTH-1:0]  d_next;

    // Stage 0: shift the accepted sample into cur, old cur into prev.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_re  <= '0;
            cur_im  <= '0;
            prev_re <= '0;
            prev_im <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= start_i;
            if (start_i) begin
                prev_re <= cur_re;
                prev_im <= cur_im;
                cur_re  <= real_i;
                cur_im  <= imag_i;
            end
        end
    end

    // Discriminator arithmetic: full precision, scale, then saturate.
    always_comb begin
        prod_a     = PROD_W'(prev_re) * PROD_W'(cur_im);
        prod_b     = PROD_W'(prev_im) * PROD_W'(cur_re);
        disc       = prod_a - prod_b;
`ifdef AVG_128_DEMOD_ROUND_EN
        disc_adj   = disc + HALF;
`else
        disc_adj   = disc;
`endif
        disc_shift = disc_adj >>> SHIFT;
        d_next     = WIDTH'(sat_to_width(64'(disc_shift), WIDTH));
    end

    // Stage 1: register the scaled discriminator value and its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d       <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= v1;
            if (v1) begin
                d <= d_next;
            end
        end
    end

endmodule

// File: rtl/avg_128_demod.sv
// FM discriminator followed by a 2^AVG_LOG2-tap moving average.
// Optional build macro: AVG_128_DEMOD_ROUND_EN (round half-up on both shifts).
module avg_128_demod
    import avg_128_demod_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic signed [WIDTH-1:0] real_i,
    input  logic signed [WIDTH-1:0] imag_i,
    output logic signed [WIDTH-1:0] demod_o
);

    localparam int unsigned WIN   = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = sum_width(WIDTH, AVG_LOG2);
    localparam int unsigned AVG_W = SUM_W + 1;
`ifdef AVG_128_DEMOD_ROUND_EN
    localparam logic signed [AVG_W-1:0] HALF = AVG_W'(1) << (AVG_LOG2 - 1);
`endif

    logic signed [WIDTH-1:0] d;
    logic                    d_valid;
    logic signed [WIDTH-1:0] win [WIN];
    logic [AVG_LOG2-1:0]     wptr;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [AVG_W-1:0] avg_src;

    avg_128_demod_conj_disc #(
        .WIDTH (WIDTH)
    ) u_conj_disc (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .real_i  (real_i),
        .imag_i  (imag_i),
        .d       (d),
        .d_valid (d_valid)
    );

    // Running sum: add newest value, drop the one written WIN updates ago.
    always_comb begin
        sum_next = sum + SUM_W'(d) - SUM_W'(win[wptr]);
`ifdef AVG_128_DEMOD_ROUND_EN
        avg_src  = AVG_W'(sum_next) + HALF;
`else
        avg_src  = AVG_W'(sum_next);
`endif
    end

    // Stage 2: window write, pointer advance, sum and output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                win[i] <= '0;
            end
            wptr    <= '0;
            sum     <= '0;
            demod_o <= '0;
        end else if (d_valid) begin
            win[wptr] <= d;
            wptr      <= wptr + 1'b1;
            sum       <= sum_next;
            demod_o   <= WIDTH'(avg_src >>> AVG_LOG2);
        end
    end

endmodule

// File: tb/tb_avg_128_demod.sv
// Directed bench for avg_128_demod (WIDTH=16, AVG_LOG2=7, truncating build).
// Each stimulus step carries the hand-derived discriminator value for the
// sample; a 2-stage delay plus a brute-force 128-entry average predicts demod_o.
module tb_avg_128_demod;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic signed [15:0] real_i;
    logic signed [15:0] imag_i;
    logic signed [15:0] demod_o;

    int checks = 0;
    int errors = 0;

    int hist [128];
    int hp;
    bit mv1, mv2;
    int md1, md2;
    int exp_demod;

    always #5 clk = ~clk;

    avg_128_demod #(
        .WIDTH    (16),
        .AVG_LOG2 (7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .real_i  (real_i),
        .imag_i  (imag_i),
        .demod_o (demod_o)
    );

    task automatic check_eq(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) hist[i] = 0;
        hp = 0;
        mv1 = 1'b0;
        mv2 = 1'b0;
        md1 = 0;
        md2 = 0;
        exp_demod = 0;
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare 1 time unit later.
    task automatic step(input bit s, input int r, input int im, input int ed, input string tag);
        int total;
        @(negedge clk);
        start_i = s;
        real_i  = 16'(r);
        imag_i  = 16'(im);
        @(posedge clk);
        if (mv2) begin
            hist[hp] = md2;
            hp = (hp + 1) % 128;
            total = 0;
            for (int i = 0; i < 128; i++) total += hist[i];
            exp_demod = total >>> 7;
        end
        mv2 = mv1;
        md2 = md1;
        mv1 = s;
        md1 = ed;
        #1;
        check_eq(tag, int'(demod_o), exp_demod);
    endtask

    // Reset asserted between edges: output must clear before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq(tag, int'(demod_o), 0);
        model_clear();
        start_i = 1'b0;
        real_i  = '0;
        imag_i  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rot_sample(input int k, output int r, output int im);
        case (k % 4)
            0:       begin r = 16384;  im = 0;      end
            1:       begin r = 0;      im = 16384;  end
            2:       begin r = -16384; im = 0;      end
            default: begin r = 0;      im = -16384; end
        endcase
    endtask

    initial begin
        int r, im, n, cnt;
        model_clear();
        rst     = 1'b1;
        start_i = 1'b0;
        real_i  = '0;
        imag_i  = '0;
        #12;
        check_eq("por_reset", int'(demod_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int t = 0; t < 20; t++) step(1'b0, 0, 0, 0, "idle");

        // Constant phasor gives zero discriminator
        for (int t = 0; t < 300; t++) step(1'b1, 1000, 0, 0, "const");
        for (int t = 0; t < 2; t++) step(1'b0, 0, 0, 0, "const_drain");

        // Rotating phasor, continuous strobes: ramp of 64 per sample to 8192
        do_reset("rst_rot");
        for (int t = 0; t < 200; t++) begin
            rot_sample(t, r, im);
            step(1'b1, r, im, (t == 0) ? 0 : 8192, "rot");
        end
        for (int t = 0; t < 2; t++) step(1'b0, 0, 0, 0, "rot_drain");
        check_eq("rot_settle", int'(demod_o), 8192);

        // Saturation: one d=32767 lives in the window for exactly 128 updates
        do_reset("rst_sat");
        cnt = 0;
        step(1'b1, 0, 0, 0, "sat");
        if (demod_o == 16'sd255) cnt++;
        step(1'b1, 32767, -32768, 0, "sat");
        if (demod_o == 16'sd255) cnt++;
        step(1'b1, 32767, 32767, 32767, "sat");
        if (demod_o == 16'sd255) cnt++;
        for (int t = 0; t < 160; t++) begin
            step(1'b1, 0, 0, 0, "sat");
            if (demod_o == 16'sd255) cnt++;
        end
        check_eq("sat_count", cnt, 128);
        check_eq("sat_expired", int'(demod_o), 0);

        // Gapped strobes 1,0,0: same values as continuous, output moves 2 edges later
        do_reset("rst_gap");
        n = 0;
        for (int t = 0; t < 420; t++) begin
            if (t % 3 == 0) begin
                rot_sample(n, r, im);
                step(1'b1, r, im, (n == 0) ? 0 : 8192, "gap");
                n++;
            end else begin
                step(1'b0, 0, 0, 0, "gap");
            end
        end
        for (int t = 0; t < 2; t++) step(1'b0, 0, 0, 0, "gap_drain");
        check_eq("gap_settle", int'(demod_o), 8192);

        // Mid-run reset during ramp: ramp restarts from 0
        do_reset("rst_mid_pre");
        for (int t = 0; t < 60; t++) begin
            rot_sample(t, r, im);
            step(1'b1, r, im, (t == 0) ? 0 : 8192, "mid_a");
        end
        check_eq("mid_before", int'(demod_o), 64 * 57);
        do_reset("rst_mid");
        for (int t = 0; t < 140; t++) begin
            rot_sample(t, r, im);
            step(1'b1, r, im, (t == 0) ? 0 : 8192, "mid_b");
            if (t == 3) check_eq("mid_restart", int'(demod_o), 64);
        end
        for (int t = 0; t < 2; t++) step(1'b0, 0, 0, 0, "mid_drain");
        check_eq("mid_settle", int'(demod_o), 8192);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avg_128_demod.md
Name: avg_128_demod

Overview:
- FM discriminator plus 128-tap moving average for the complex-baseband demodulator path.
- Each accepted I/Q sample is conjugate-multiplied with the previous accepted sample: Im{x[n]·conj(x[n-1])}.
- The scaled, saturated result is averaged over the last 128 discriminator values and driven out as the demodulated audio sample.
- Sits between the I/Q front-end (decimated baseband) and the audio/output stage.

Parameters:
- WIDTH, 16, signed width of real_i, imag_i and demod_o.
- AVG_LOG2, 7, log2 of window length; window = 2^AVG_LOG2 = 128 samples.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  sample strobe; real_i/imag_i are accepted on each rising edge with start_i=1.
- real_i  input  WIDTH  signed in-phase sample.
- imag_i  input  WIDTH  signed quadrature sample.
- demod_o  output  WIDTH  signed averaged discriminator output, registered.

Behaviour:
- Reset (async, rst=1): clears the following to 0.
  - cur/prev sample registers
  - stage valid flags
  - discriminator register
  - all 128 window entries
  - running sum
  - write pointer
  - demod_o
- Stage 0 (edge with start_i=1): prev <= cur; cur <= {real_i, imag_i}; v1 <= 1. If start_i=0, then v1 <= 0 and cur/prev hold.
- Stage 1 (edge with v1=1): disc = prev_r·cur_i − prev_i·cur_r.
  - Full precision is 2·WIDTH+1 signed bits.
  - d = disc >>> (WIDTH−1), arithmetic shift with truncation toward −inf.
  - d is saturated to the signed WIDTH range [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Register d and set v2 <= 1; v2 <= 0 when v1=0.
- Stage 2 (edge with v2=1): window update.
  - sum_next = sum + d − win[wptr]
  - win[wptr] <= d
  - wptr <= wptr+1, wrapping modulo 128
  - sum <= sum_next
  - demod_o <= sum_next >>> AVG_LOG2, truncated
- Sum width is WIDTH+AVG_LOG2 signed, so it never overflows.
- Latency: a sample accepted at edge k affects demod_o after edge k+2. Throughput is one sample per clock.
- The window is zero-initialised. During the first 128 discriminator values, the output is the sum divided by 128, not by the fill count; the ramp is intended.
- The first sample after reset has prev=0, so its discriminator value is 0.
- Gaps (start_i=0): no window update. demod_o holds its last value, and the pipeline drains in-flight samples normally.
- Back-to-back strobes are fully supported; no backpressure.
- Reset mid-operation discards all in-flight samples and all window history.
- Window storage may be registers or an inferred RAM. The read of win[wptr] must be the value written 128 updates earlier.

Optional Feature:
- AVG_128_DEMOD_ROUND_EN defined: both shifts (the >>> (WIDTH−1) scaling and the >>> AVG_LOG2 average) round half-up. This is done by adding 2^(shift−1) before shifting; saturation is applied after rounding.
- Not defined: plain truncating arithmetic shifts as above.
- Latency is identical either way.

Decomposition:
- Shared package holds:
  - default WIDTH and AVG_LOG2
  - a saturate-to-WIDTH function
  - the product/sum width constants (2·WIDTH+1, WIDTH+AVG_LOG2)
- One natural sub-module: conj_disc, covering stages 0–1. It takes the sample and strobe and outputs d with its valid. The top keeps the moving-average window.

Test Plan (WIDTH=16, truncating):
- Reset:
  - Assert rst asynchronously mid-cycle → demod_o=0 immediately.
  - After release with start_i=0 for 20 cycles → demod_o stays 0.
- Constant phasor (1000,0) strobed for 300 cycles → disc=0 every sample, demod_o=0 throughout.
- Rotating phasor (16384,0),(0,16384),(−16384,0),(0,−16384), repeating, start_i=1 continuously:
  - d=8192 from the 2nd sample on.
  - demod_o ramps by 64 per sample.
  - demod_o settles at 8192 once 128 non-zero d fill the window.
- Saturation and window expiry:
  - Sequence (0,0),(32767,−32768),(32767,32767),(0,0), then zeros → single d saturates to 32767.
  - demod_o=255 for exactly 128 updates, then returns to 0.
- Gaps: rotating phasor with start_i toggling 1,0,0,1,… → demod_o changes only 2 edges after each accepted sample. Values match the continuous case sample-for-sample.
- Mid-run reset: pulse rst during the rotating-phasor test → outputs and window cleared. The ramp restarts from 0 exactly as after power-on.
